// File: rtl/frame_step_sequencer.sv
// frame_step_sequencer
//   Paces the snake game logic off the display timing. Every SPEED frames,
//   at the start of vertical sync, it runs move -> collision check -> food
//   placement over shared game state. Each step is a req/done handshake.
//   A game-state update that is still running when the active area begins
//   is flagged on overrun.
//
// Ports
//   clk_disp            pixel clock, all logic on posedge
//   rst                 asynchronous active-high reset
//   v_sync, inrange     display timing (v_sync low during sync lines)
//   enable, speed       run control; speed 0 selects DEF_SPEED
//   restart             one-cycle pulse, back to IDLE with flags cleared
//   move_req/move_done  snake move handshake
//   coll_req/coll_done  collision/eat check, coll_hit/ate valid with done
//   food_req/food_done  food placement handshake
//   step_pulse          one cycle at sequence start
//   busy                sequence in progress
//   game_over, overrun  sticky status flags
module frame_step_sequencer #(
   parameter int                 SPEED_W   = 4,
   parameter logic [SPEED_W-1:0] DEF_SPEED = 4'd8
) (
   input  logic               clk_disp,
   input  logic               rst,
   input  logic               v_sync,
   input  logic               inrange,
   input  logic               enable,
   input  logic [SPEED_W-1:0] speed,
   input  logic               restart,
   output logic               move_req,
   input  logic               move_done,
   output logic               coll_req,
   input  logic               coll_done,
   input  logic               coll_hit,
   input  logic               ate,
   output logic               food_req,
   input  logic               food_done,
   output logic               step_pulse,
   output logic               busy,
   output logic               game_over,
   output logic               overrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MOVE,
      S_CHECK,
      S_FOOD,
      S_OVER
   } state_t;

   state_t             state_q;
   logic [SPEED_W-1:0] frame_cnt_q;
   logic               vsync_q;
   logic               inr_q;
   logic               move_req_q;
   logic               coll_req_q;
   logic               food_req_q;
   logic               step_pulse_q;
   logic               game_over_q;
   logic               overrun_q;

   logic [SPEED_W-1:0] eff_speed;
   logic [SPEED_W-1:0] last_cnt;
   logic               frame_tick;
   logic               inr_rise;

   assign eff_speed  = (speed == '0) ? DEF_SPEED : speed;
   assign last_cnt   = eff_speed - SPEED_W'(1);
   // Falling edge of v_sync marks the start of the vertical sync lines.
   assign frame_tick = vsync_q & ~v_sync;
   assign inr_rise   = inrange & ~inr_q;

   assign busy = (state_q == S_MOVE) || (state_q == S_CHECK) || (state_q == S_FOOD);

   assign move_req   = move_req_q;
   assign coll_req   = coll_req_q;
   assign food_req   = food_req_q;
   assign step_pulse = step_pulse_q;
   assign game_over  = game_over_q;
   assign overrun    = overrun_q;

   // Each request rises one cycle after its state is entered. Done is only
   // honoured once the request is visible, so a done that arrives in the
   // same cycle as the rising request is accepted, and the request falls on
   // the following edge together with the state change.
   always_ff @(posedge clk_disp or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         frame_cnt_q  <= '0;
         vsync_q      <= 1'b1;
         inr_q        <= 1'b0;
         move_req_q   <= 1'b0;
         coll_req_q   <= 1'b0;
         food_req_q   <= 1'b0;
         step_pulse_q <= 1'b0;
         game_over_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         vsync_q      <= v_sync;
         inr_q        <= inrange;
         step_pulse_q <= 1'b0;
         if (restart) begin
            // Any done in this cycle is dropped; reqs are withdrawn.
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            move_req_q  <= 1'b0;
            coll_req_q  <= 1'b0;
            food_req_q  <= 1'b0;
            game_over_q <= 1'b0;
            overrun_q   <= 1'b0;
         end else begin
            if (inr_rise && busy)
               overrun_q <= 1'b1;
            case (state_q)
               S_IDLE: begin
                  // Ticks outside IDLE are never counted, so steps never queue.
                  if (frame_tick && enable) begin
                     if (frame_cnt_q >= last_cnt) begin
                        frame_cnt_q  <= '0;
                        step_pulse_q <= 1'b1;
                        state_q      <= S_MOVE;
                     end else begin
                        frame_cnt_q <= frame_cnt_q + SPEED_W'(1);
                     end
                  end
               end
               S_MOVE: begin
                  if (!move_req_q) begin
                     move_req_q <= 1'b1;
                  end else if (move_done) begin
                     move_req_q <= 1'b0;
                     state_q    <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  if (!coll_req_q) begin
                     coll_req_q <= 1'b1;
                  end else if (coll_done) begin
                     coll_req_q <= 1'b0;
                     if (coll_hit) begin
                        state_q     <= S_OVER;
                        game_over_q <= 1'b1;
                     end else if (ate) begin
                        state_q <= S_FOOD;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end
               end
               S_FOOD: begin
                  if (!food_req_q) begin
                     food_req_q <= 1'b1;
                  end else if (food_done) begin
                     food_req_q <= 1'b0;
                     state_q    <= S_IDLE;
                  end
               end
               S_OVER: begin
                  // Frozen until restart.
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_frame_step_sequencer.sv
module tb_frame_step_sequencer;

   logic       clk_disp = 1'b0;
   logic       rst;
   logic       v_sync;
   logic       inrange;
   logic       enable;
   logic [3:0] speed;
   logic       restart;
   logic       move_req, coll_req, food_req;
   logic       move_done, coll_done, coll_hit, ate, food_done;
   logic       step_pulse, busy, game_over, overrun;

   // Manual drive (directed tests) and automatic responder, muxed by auto.
   logic auto;
   logic m_move_done, m_coll_done, m_coll_hit, m_ate, m_food_done;
   logic r_move_done, r_coll_done, r_ate, r_food_done;

   assign move_done = auto ? r_move_done : m_move_done;
   assign coll_done = auto ? r_coll_done : m_coll_done;
   assign coll_hit  = auto ? 1'b0        : m_coll_hit;
   assign ate       = auto ? r_ate       : m_ate;
   assign food_done = auto ? r_food_done : m_food_done;

   int checks = 0;
   int errors = 0;

   // Observation counters, written only by the monitor.
   int n_step = 0;
   int n_food = 0;
   logic food_prev = 1'b0;

   // Responder bookkeeping, written only by the responder.
   int exp_food = 0;
   int wcnt = 0;
   int wtgt = 0;

   // Reference model state.
   int m_cnt;
   int m_steps;

   always #5 clk_disp = ~clk_disp;

   frame_step_sequencer #(.SPEED_W(4), .DEF_SPEED(4'd8)) dut (
      .clk_disp  (clk_disp),
      .rst       (rst),
      .v_sync    (v_sync),
      .inrange   (inrange),
      .enable    (enable),
      .speed     (speed),
      .restart   (restart),
      .move_req  (move_req),
      .move_done (move_done),
      .coll_req  (coll_req),
      .coll_done (coll_done),
      .coll_hit  (coll_hit),
      .ate       (ate),
      .food_req  (food_req),
      .food_done (food_done),
      .step_pulse(step_pulse),
      .busy      (busy),
      .game_over (game_over),
      .overrun   (overrun)
   );

   always @(posedge clk_disp) begin
      #1;
      if (step_pulse === 1'b1) n_step = n_step + 1;
      if (food_req === 1'b1 && food_prev !== 1'b1) n_food = n_food + 1;
      food_prev = food_req;
   end

   // Game-logic stand-in: answers whichever request is up after 0..3 cycles.
   always @(negedge clk_disp) begin
      r_move_done = 1'b0;
      r_coll_done = 1'b0;
      r_food_done = 1'b0;
      r_ate       = 1'b0;
      if (auto === 1'b1 && (move_req | coll_req | food_req) === 1'b1) begin
         if (wcnt >= wtgt) begin
            r_move_done = move_req;
            r_coll_done = coll_req;
            r_food_done = food_req;
            r_ate       = 1'($urandom_range(0, 1));
            if (coll_req === 1'b1 && r_ate) exp_food = exp_food + 1;
            wcnt = 0;
            wtgt = $urandom_range(0, 3);
         end else begin
            wcnt = wcnt + 1;
         end
      end
   end

   task automatic cyc();
      @(posedge clk_disp);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp)
      else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frames per step the spec asks for, and one frame's worth of bookkeeping.
   task automatic model_tick();
      int eff;
      if (enable) begin
         eff = (speed == 0) ? 8 : int'(speed);
         m_cnt = m_cnt + 1;
         if (m_cnt >= eff) begin
            m_cnt   = 0;
            m_steps = m_steps + 1;
         end
      end
   endtask

   // One frame: sync lines, blanking (sequence runs here), active area.
   task automatic frame(input int act);
      v_sync = 1'b0;
      model_tick();
      repeat (3) cyc();
      v_sync = 1'b1;
      repeat (40) cyc();
      inrange = 1'b1;
      repeat (act) cyc();
      inrange = 1'b0;
      repeat (2) cyc();
   endtask

   task automatic do_restart();
      restart = 1'b1;
      cyc();
      restart = 1'b0;
      m_cnt = 0;
   endtask

   task automatic tick_only();
      v_sync = 1'b0;
      cyc();
      v_sync = 1'b1;
   endtask

   task automatic wait_req(input int sel, input string tag);
      int n = 0;
      while (!((sel == 0) ? move_req : (sel == 1) ? coll_req : food_req) && n < 50) begin
         cyc();
         n = n + 1;
      end
      check(tag, 32'(n < 50), 32'd1);
   endtask

   initial begin
      int s0, f0, ef0;
      rst = 1'b1; v_sync = 1'b1; inrange = 1'b0; enable = 1'b0; speed = 4'd0;
      restart = 1'b0; auto = 1'b1;
      m_move_done = 1'b0; m_coll_done = 1'b0; m_coll_hit = 1'b0; m_ate = 1'b0; m_food_done = 1'b0;
      m_cnt = 0; m_steps = 0;
      repeat (3) cyc();
      check("reset_outputs", 32'({move_req, coll_req, food_req, step_pulse, busy, game_over, overrun}), 32'd0);
      rst = 1'b0;
      cyc();

      // speed=2: steps after the 2nd and 4th ticks.
      speed = 4'd2; enable = 1'b1;
      s0 = n_step;
      for (int k = 1; k <= 5; k++) begin
         frame(10);
         check($sformatf("spd2_steps_f%0d", k), 32'(n_step - s0), 32'(m_steps));
         check($sformatf("spd2_cnt_f%0d", k), 32'(dut.frame_cnt_q), 32'(m_cnt));
      end
      check("spd2_total", 32'(n_step - s0), 32'd2);

      // speed=0 -> default 8 frames.
      do_restart();
      speed = 4'd0;
      s0 = n_step; m_steps = 0;
      for (int k = 1; k <= 8; k++) begin
         frame(10);
         check($sformatf("spd0_steps_f%0d", k), 32'(n_step - s0), 32'(m_steps));
      end
      check("spd0_total", 32'(n_step - s0), 32'd1);

      // Randomized speed/enable against the model.
      s0 = n_step; f0 = n_food; ef0 = exp_food; m_steps = 0;
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 3) == 0) speed = 4'($urandom_range(0, 4));
         enable = ($urandom_range(0, 4) != 0);
         frame($urandom_range(5, 20));
         check("rnd_steps", 32'(n_step - s0), 32'(m_steps));
         check("rnd_food", 32'(n_food - f0), 32'(exp_food - ef0));
         check("rnd_flags", 32'({game_over, overrun, busy}), 32'd0);
      end

      // Directed handshake: move (3-cycle latency), check with ate, food.
      auto = 1'b0; enable = 1'b1; speed = 4'd1;
      do_restart();
      repeat (2) cyc();
      tick_only();
      check("hs_step_pulse", 32'({step_pulse, busy, move_req}), 32'b110);
      cyc();
      check("hs_move_req", 32'({move_req, coll_req, food_req}), 32'b100);
      repeat (3) cyc();
      m_move_done = 1'b1;
      cyc();
      m_move_done = 1'b0;
      check("hs_move_drop", 32'({move_req, coll_req, busy}), 32'b001);
      cyc();
      check("hs_coll_req", 32'({move_req, coll_req, food_req}), 32'b010);
      m_coll_done = 1'b1; m_ate = 1'b1;
      cyc();
      m_coll_done = 1'b0; m_ate = 1'b0;
      check("hs_coll_drop", 32'({coll_req, food_req, busy}), 32'b001);
      cyc();
      check("hs_food_req", 32'({move_req, coll_req, food_req}), 32'b001);
      m_food_done = 1'b1;
      cyc();
      m_food_done = 1'b0;
      check("hs_done", 32'({food_req, busy, game_over}), 32'b000);

      // Collision with ate also set: hit wins, game over, ticks ignored.
      tick_only();
      wait_req(0, "col_wait_move");
      m_move_done = 1'b1; cyc(); m_move_done = 1'b0;
      wait_req(1, "col_wait_coll");
      m_coll_done = 1'b1; m_coll_hit = 1'b1; m_ate = 1'b1;
      cyc();
      m_coll_done = 1'b0; m_coll_hit = 1'b0; m_ate = 1'b0;
      check("col_over", 32'({game_over, busy, coll_req}), 32'b100);
      s0 = n_step; f0 = n_food;
      repeat (3) cyc();
      tick_only(); repeat (5) cyc();
      tick_only(); repeat (5) cyc();
      check("col_no_food", 32'(n_food - f0), 32'd0);
      check("col_no_step", 32'(n_step - s0), 32'd0);
      check("col_sticky", 32'(game_over), 32'd1);
      do_restart();
      check("col_restart", 32'({game_over, busy}), 32'b00);
      check("col_restart_cnt", 32'(dut.frame_cnt_q), 32'd0);

      // Overrun: active area begins while the move is outstanding.
      tick_only();
      wait_req(0, "ovr_wait_move");
      inrange = 1'b1;
      repeat (2) cyc();
      check("ovr_set", 32'({overrun, busy, move_req}), 32'b111);
      m_move_done = 1'b1; cyc(); m_move_done = 1'b0;
      wait_req(1, "ovr_wait_coll");
      m_coll_done = 1'b1; cyc(); m_coll_done = 1'b0;
      cyc();
      check("ovr_complete", 32'({busy, overrun, food_req}), 32'b010);
      inrange = 1'b0;
      repeat (3) cyc();
      check("ovr_sticky", 32'(overrun), 32'd1);
      do_restart();
      check("ovr_clear", 32'(overrun), 32'd0);

      // Asynchronous reset while coll_req is high.
      tick_only();
      wait_req(0, "ar_wait_move");
      m_move_done = 1'b1; cyc(); m_move_done = 1'b0;
      wait_req(1, "ar_wait_coll");
      #2 rst = 1'b1;
      #1 check("ar_immediate", 32'({coll_req, busy, step_pulse}), 32'b000);
      cyc();
      rst = 1'b0;
      repeat (3) cyc();
      check("ar_idle", 32'({busy, move_req, coll_req, food_req}), 32'd0);
      check("ar_state", 32'(dut.state_q), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_step_sequencer.md
Name: frame_step_sequencer

Overview:
- Schedules the snake game-logic updates during vertical blanking of the 480x272 display timing.
- Counts frames, and every SPEED frames runs a fixed sequence over shared game state: move → collision check → food placement. Each step is a req/done handshake.
- Keeps game-state writes out of the active display window and flags any update that spills into it.
- Sits between the display timing generator (v_sync, inrange) and the game-logic blocks.

Parameters:
- SPEED_W, 4, width of the speed input.
- DEF_SPEED, 4'd8, frames per step used while speed input is 0.

Ports:
- clk_disp  input  1  display pixel clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- v_sync  input  1  from timing generator: low during the vertical sync lines, high otherwise.
- inrange  input  1  from timing generator: high while the pixel is inside the 480x272 active area.
- enable  input  1  game running; when low no new sequence starts.
- speed  input  SPEED_W  frames per step; 0 selects DEF_SPEED.
- restart  input  1  one-cycle pulse; clears game_over and overrun, returns to IDLE.
- move_req  output  1  request snake move.
- move_done  input  1  move complete.
- coll_req  output  1  request collision/eat check.
- coll_done  input  1  check complete; coll_hit and ate are valid in the same cycle.
- coll_hit  input  1  snake hit wall or body.
- ate  input  1  head is on food.
- food_req  output  1  request new food placement.
- food_done  input  1  placement complete.
- step_pulse  output  1  one cycle at sequence start.
- busy  output  1  high in MOVE, CHECK or FOOD.
- game_over  output  1  sticky collision flag.
- overrun  output  1  sticky flag: inrange rose while busy.

Behaviour:
- Reset: all outputs 0; frame_cnt = 0; state = IDLE; v_sync history register = 1; inrange history register = 0.
- Frame tick: v_sync is registered. frame_tick = previous 1 and current 0, i.e. start of vertical sync. v_sync held low by the generator during its own reset produces at most one tick; that is acceptable.
- frame_cnt (SPEED_W bits) increments on frame_tick while enable=1 and state=IDLE.
  - When frame_cnt == eff_speed-1 on a tick, frame_cnt clears to 0 and a sequence starts. eff_speed = speed, or DEF_SPEED if speed = 0.
  - With speed = 1, every frame steps.
  - A speed change takes effect at the next tick. If frame_cnt is already ≥ eff_speed-1, the next tick starts a sequence.
- States:
  - IDLE: on a start condition, pulse step_pulse and go to MOVE.
  - MOVE: move_req=1. On move_done, move_req drops the next cycle and the state goes to CHECK.
  - CHECK: coll_req=1. On coll_done, sample coll_hit and ate.
    - coll_hit=1 → OVER (hit has priority over ate).
    - else ate=1 → FOOD.
    - else → IDLE.
  - FOOD: food_req=1. On food_done → IDLE.
  - OVER: all reqs 0, game_over=1; frame_cnt frozen. Only restart leaves it.
- Handshake:
  - req is a registered output, high from the cycle after the state is entered until the cycle after done is seen.
  - done is ignored outside its own state.
  - done asserted in the same cycle req rises is accepted.
  - No timeout: the sequencer waits indefinitely.
- Overrun: registered inrange rising edge while busy=1 sets overrun. The sequence is not aborted.
- restart: has priority over every state and transition. Next cycle: state=IDLE, all reqs 0, frame_cnt=0, game_over=0, overrun=0.
  - A done arriving in the same cycle as restart is dropped.
  - Game logic must tolerate a req being withdrawn mid-handshake.
- enable=0 mid-sequence: the sequence completes, and no new sequence starts.
- frame_tick while busy: the tick is not counted. Steps never queue.
- busy = (state in MOVE, CHECK, FOOD), combinational from the state register.

Test Plan:
- Reset, speed=2, enable=1, generate 5 frames of v_sync → step_pulse after the 2nd and 4th ticks only; frame_cnt returns to 0.
- speed=0, enable=1, 8 ticks → exactly one step_pulse, on the 8th tick.
- One sequence with move_done 3 cycles after move_req, coll_done with hit=0 and ate=1, then food_done → req order is move, coll, food. Each req drops the cycle after its done; busy low afterwards; no game_over.
- coll_done with coll_hit=1 and ate=1 → no food_req; game_over=1. Further ticks give no step_pulse; a restart pulse clears game_over and frame_cnt.
- Hold move_done low past the start of the active area (inrange 0→1) → overrun=1, sequence still completes on move_done; overrun clears only on restart.
- Assert rst asynchronously while coll_req is high → coll_req, busy and step_pulse go low immediately with no clock edge; state is IDLE after release.
